// File: rtl/gpio_cmd_pkg.sv
// Shared definitions for the GPIO command frame decoder.
// Holds the frame constants, the FSM state encoding, the configuration-target
// encoding and a helper that decodes the param byte.
package gpio_cmd_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned FRAME_DATA_W = 24;
  localparam int unsigned CNT_W        = 2;

  localparam logic [BYTE_W-1:0] CMD_GPIO    = 8'h47;  // 'G'
  localparam logic [BYTE_W-1:0] LEN_GPIO    = 8'h04;  // param + 3 data bytes
  localparam logic [BYTE_W-1:0] PARAM_LEVEL = 8'h6c;  // 'l'
  localparam logic [BYTE_W-1:0] PARAM_DIR   = 8'h64;  // 'd'
  localparam logic [BYTE_W-1:0] PARAM_INTEN = 8'h69;  // 'i'

  // Count value seen when the third (final) data byte arrives.
  localparam logic [CNT_W-1:0] LAST_DATA_CNT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVID,
    ST_LEN,
    ST_PARAM,
    ST_DATA,
    ST_WAIT_END,
    ST_DRAIN,
    ST_ACK
  } state_e;

  typedef enum logic [1:0] {
    TGT_LEVEL,
    TGT_DIR,
    TGT_INTEN
  } target_e;

  typedef struct packed {
    logic    ok;
    target_e tgt;
  } param_dec_t;

  // Map a param byte onto a configuration register; ok=0 for unknown params.
  function automatic param_dec_t param_decode(input logic [BYTE_W-1:0] p);
    param_dec_t r;
    r.ok  = 1'b1;
    r.tgt = TGT_LEVEL;
    case (p)
      PARAM_LEVEL: r.tgt = TGT_LEVEL;
      PARAM_DIR:   r.tgt = TGT_DIR;
      PARAM_INTEN: r.tgt = TGT_INTEN;
      default:     r.ok  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpio_cmd_shreg.sv
// 24-bit MSB-first byte shift register with a load counter.
// Ports:
//   clk, reset      clock, async active-low reset
//   clr_i           synchronous clear of shadow and count
//   shift_i         shift byte_i in at the LSB end
//   byte_i          incoming data byte
//   cnt_o           number of bytes loaded since the last clear (wraps)
//   data_next_c     combinational view of the shadow including this cycle's byte
module gpio_cmd_shreg
  import gpio_cmd_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    shift_i,
  input  logic [BYTE_W-1:0]       byte_i,
  output logic [CNT_W-1:0]        cnt_o,
  output logic [FRAME_DATA_W-1:0] data_next_c
);

  logic [FRAME_DATA_W-1:0] data_q;
  logic [CNT_W-1:0]        cnt_q;

  // Exposing the post-shift value lets a final byte commit in its own cycle.
  always_comb begin
    data_next_c = data_q;
    if (shift_i) begin
      data_next_c = {data_q[FRAME_DATA_W-BYTE_W-1:0], byte_i};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (shift_i) begin
      data_q <= data_next_c;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gpio_cmd.sv
// GPIO command frame decoder: parses 'G' frames, updates one of the GPIO
// level/direction/interrupt-enable registers and returns an ACK or NAK.
// Ports:
//   clk, reset                         clock, async active-low reset
//   in_frame_valid                     high for the whole inbound frame
//   in_frame_data, in_frame_data_valid inbound byte and its strobe
//   in_frame_ready                     low while an ack is pending
//   gpio_level/direction/int_enable    registered GPIO configuration
//   ack_valid, ack_ok, ack_event_id    ack/nak result, held until ack_ready
//   ack_ready                          consumer accepts the ack
module gpio_cmd
  import gpio_cmd_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_frame_valid,
  input  logic [BYTE_W-1:0]     in_frame_data,
  input  logic                  in_frame_data_valid,
  output logic                  in_frame_ready,
  output logic [GPIO_WIDTH-1:0] gpio_level,
  output logic [GPIO_WIDTH-1:0] gpio_direction,
  output logic [GPIO_WIDTH-1:0] gpio_int_enable,
  output logic                  ack_valid,
  output logic                  ack_ok,
  output logic [BYTE_W-1:0]     ack_event_id,
  input  logic                  ack_ready
);

  state_e                  state_q, state_d;
  target_e                 tgt_q, tgt_d;
  logic                    nak_q, nak_d;
  logic                    ack_ok_q, ack_ok_d;
  logic [BYTE_W-1:0]       evid_q, evid_d;
  logic                    ready_q;
  logic                    ack_valid_q;
  logic [GPIO_WIDTH-1:0]   level_q, level_d;
  logic [GPIO_WIDTH-1:0]   dir_q, dir_d;
  logic [GPIO_WIDTH-1:0]   inten_q, inten_d;

  logic                    fire_c;
  logic                    fv_c;
  logic                    shift_c;
  logic                    clr_c;
  logic                    commit_c;
  logic [CNT_W-1:0]        cnt;
  logic [FRAME_DATA_W-1:0] shadow_next_c;
  param_dec_t              dec_c;

  gpio_cmd_shreg u_shreg (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (clr_c),
    .shift_i     (shift_c),
    .byte_i      (in_frame_data),
    .cnt_o       (cnt),
    .data_next_c (shadow_next_c)
  );

  assign fire_c = in_frame_data_valid & ready_q;
  assign fv_c   = in_frame_valid;
  assign dec_c  = param_decode(in_frame_data);

  // Frame parser. A byte arriving with in_frame_valid already low is taken
  // as the last byte, and the end-of-frame is handled in the same cycle.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    nak_d    = nak_q;
    ack_ok_d = ack_ok_q;
    evid_d   = evid_q;
    shift_c  = 1'b0;
    clr_c    = 1'b0;
    commit_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clr_c = 1'b1;
        nak_d = 1'b0;
        if (fire_c && fv_c) begin
          state_d = (in_frame_data == CMD_GPIO) ? ST_EVID : ST_DRAIN;
        end
      end
      ST_EVID: begin
        if (fire_c) begin
          evid_d = in_frame_data;
          if (fv_c) begin
            state_d = ST_LEN;
          end else begin
            ack_ok_d = 1'b0;
            state_d  = ST_ACK;
          end
        end else if (!fv_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (fire_c && fv_c) begin
          if (in_frame_data == LEN_GPIO) begin
            state_d = ST_PARAM;
          end else begin
            nak_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end else if (!fv_c) begin
          ack_ok_d = 1'b0;
          state_d  = ST_ACK;
        end
      end
      ST_PARAM: begin
        if (fire_c && fv_c) begin
          tgt_d = dec_c.tgt;
          if (dec_c.ok) begin
            state_d = ST_DATA;
          end else begin
            nak_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end else if (!fv_c) begin
          ack_ok_d = 1'b0;
          state_d  = ST_ACK;
        end
      end
      ST_DATA: begin
        if (fire_c) begin
          shift_c = 1'b1;
          if (cnt == LAST_DATA_CNT) begin
            if (fv_c) begin
              state_d = ST_WAIT_END;
            end else begin
              commit_c = 1'b1;
              ack_ok_d = 1'b1;
              state_d  = ST_ACK;
            end
          end else if (!fv_c) begin
            ack_ok_d = 1'b0;
            state_d  = ST_ACK;
          end
        end else if (!fv_c) begin
          ack_ok_d = 1'b0;
          state_d  = ST_ACK;
        end
      end
      ST_WAIT_END: begin
        if (fire_c) begin
          nak_d = 1'b1;
          if (fv_c) begin
            state_d = ST_DRAIN;
          end else begin
            ack_ok_d = 1'b0;
            state_d  = ST_ACK;
          end
        end else if (!fv_c) begin
          commit_c = 1'b1;
          ack_ok_d = 1'b1;
          state_d  = ST_ACK;
        end
      end
      ST_DRAIN: begin
        if (!fv_c) begin
          if (nak_q) begin
            ack_ok_d = 1'b0;
            state_d  = ST_ACK;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ACK: begin
        if (ack_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Exactly one configuration register is written on a commit.
  always_comb begin
    level_d = level_q;
    dir_d   = dir_q;
    inten_d = inten_q;
    if (commit_c) begin
      case (tgt_q)
        TGT_LEVEL: level_d = GPIO_WIDTH'(shadow_next_c);
        TGT_DIR:   dir_d   = GPIO_WIDTH'(shadow_next_c);
        TGT_INTEN: inten_d = GPIO_WIDTH'(shadow_next_c);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tgt_q       <= TGT_LEVEL;
      nak_q       <= 1'b0;
      ack_ok_q    <= 1'b0;
      evid_q      <= '0;
      ready_q     <= 1'b1;
      ack_valid_q <= 1'b0;
      level_q     <= '0;
      dir_q       <= '0;
      inten_q     <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      nak_q       <= nak_d;
      ack_ok_q    <= ack_ok_d;
      evid_q      <= evid_d;
      ready_q     <= (state_d != ST_ACK);
      ack_valid_q <= (state_d == ST_ACK);
      level_q     <= level_d;
      dir_q       <= dir_d;
      inten_q     <= inten_d;
    end
  end

  assign in_frame_ready  = ready_q;
  assign ack_valid       = ack_valid_q;
  assign ack_ok          = ack_ok_q;
  assign ack_event_id    = evid_q;
  assign gpio_level      = level_q;
  assign gpio_direction  = dir_q;
  assign gpio_int_enable = inten_q;

endmodule

// File: tb/tb_gpio_cmd.sv
// Directed, table-driven bench for gpio_cmd.
module tb_gpio_cmd;

  logic        clk;
  logic        reset;
  logic        in_frame_valid;
  logic [7:0]  in_frame_data;
  logic        in_frame_data_valid;
  logic        in_frame_ready;
  logic [23:0] gpio_level;
  logic [23:0] gpio_direction;
  logic [23:0] gpio_int_enable;
  logic        ack_valid;
  logic        ack_ok;
  logic [7:0]  ack_event_id;
  logic        ack_ready;

  int n_chk;
  int n_fail;

  gpio_cmd #(.GPIO_WIDTH(24)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_frame_valid      (in_frame_valid),
    .in_frame_data       (in_frame_data),
    .in_frame_data_valid (in_frame_data_valid),
    .in_frame_ready      (in_frame_ready),
    .gpio_level          (gpio_level),
    .gpio_direction      (gpio_direction),
    .gpio_int_enable     (gpio_int_enable),
    .ack_valid           (ack_valid),
    .ack_ok              (ack_ok),
    .ack_event_id        (ack_event_id),
    .ack_ready           (ack_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] bytes;    // byte 0 in bits [63:56]
    int          n;
    logic        simul;    // last byte arrives with in_frame_valid already low
    logic        exp_ack;
    logic        exp_ok;
    logic [7:0]  exp_id;
    logic [23:0] exp_lvl;
    logic [23:0] exp_dir;
    logic [23:0] exp_ien;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [23:0] l, input logic [23:0] d,
                            input logic [23:0] i);
    chk({tag, ".level"}, 32'(gpio_level), 32'(l));
    chk({tag, ".dir"}, 32'(gpio_direction), 32'(d));
    chk({tag, ".inten"}, 32'(gpio_int_enable), 32'(i));
  endtask

  // Waits for (or rules out) an ack after the frame end, then handshakes it.
  task automatic finish_frame(input string tag, input logic simul, input logic exp_ack,
                              input logic exp_ok, input logic [7:0] exp_id);
    int lat;
    int seen;
    in_frame_data_valid = 1'b0;
    in_frame_valid      = 1'b0;
    if (exp_ack) begin
      lat = 0;
      while (!ack_valid && lat < 8) begin
        @(posedge clk); #1;
        lat++;
      end
      chk({tag, ".ack_valid"}, 32'(ack_valid), 32'd1);
      chk({tag, ".latency"}, 32'(lat), simul ? 32'd0 : 32'd1);
      chk({tag, ".ack_ok"}, 32'(ack_ok), 32'(exp_ok));
      chk({tag, ".ack_id"}, 32'(ack_event_id), 32'(exp_id));
      chk({tag, ".ready_in_ack"}, 32'(in_frame_ready), 32'd0);
      @(posedge clk); #1;
      chk({tag, ".ack_held"}, 32'(ack_valid), 32'd1);
      ack_ready = 1'b1;
      @(posedge clk); #1;
      ack_ready = 1'b0;
      chk({tag, ".ack_cleared"}, 32'(ack_valid), 32'd0);
    end else begin
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        if (ack_valid) seen++;
      end
      chk({tag, ".no_ack"}, 32'(seen), 32'd0);
    end
    chk({tag, ".ready_after"}, 32'(in_frame_ready), 32'd1);
  endtask

  task automatic run_frame(input string tag, input logic [63:0] bytes, input int n,
                           input logic simul, input logic exp_ack, input logic exp_ok,
                           input logic [7:0] exp_id);
    for (int i = 0; i < n; i++) begin
      in_frame_valid      = 1'b1;
      in_frame_data       = bytes[63-8*i -: 8];
      in_frame_data_valid = 1'b1;
      if (simul && i == n - 1) in_frame_valid = 1'b0;
      @(posedge clk); #1;
    end
    finish_frame(tag, simul, exp_ack, exp_ok, exp_id);
  endtask

  function automatic vec_t mk(input logic [63:0] b, input int n, input logic s,
                              input logic a, input logic ok, input logic [7:0] id,
                              input logic [23:0] l, input logic [23:0] d,
                              input logic [23:0] i);
    vec_t v;
    v.bytes = b; v.n = n; v.simul = s; v.exp_ack = a; v.exp_ok = ok; v.exp_id = id;
    v.exp_lvl = l; v.exp_dir = d; v.exp_ien = i;
    return v;
  endfunction

  initial begin
    int busy;
    int lost_valid;
    n_chk  = 0;
    n_fail = 0;

    // Register state accumulates from one vector to the next.
    vt[0]  = mk(64'h47_05_04_6c_aa_55_0f_00, 7, 0, 1, 1, 8'h05, 24'haa550f, 24'h0, 24'h0);
    vt[1]  = mk(64'h47_09_04_7a_01_02_03_00, 7, 0, 1, 0, 8'h09, 24'haa550f, 24'h0, 24'h0);
    vt[2]  = mk(64'h47_11_04_64_ff_00_00_00, 5, 0, 1, 0, 8'h11, 24'haa550f, 24'h0, 24'h0);
    vt[3]  = mk(64'h47_12_04_69_00_00_01_ee, 8, 0, 1, 0, 8'h12, 24'haa550f, 24'h0, 24'h0);
    vt[4]  = mk(64'h47_20_04_64_12_34_56_00, 7, 0, 1, 1, 8'h20, 24'haa550f, 24'h123456, 24'h0);
    vt[5]  = mk(64'h47_21_04_69_00_00_81_00, 7, 0, 1, 1, 8'h21, 24'haa550f, 24'h123456, 24'h000081);
    vt[6]  = mk(64'h47_22_03_6c_01_02_03_00, 7, 0, 1, 0, 8'h22, 24'haa550f, 24'h123456, 24'h000081);
    vt[7]  = mk(64'h50_01_02_00_00_00_00_00, 3, 0, 0, 0, 8'h00, 24'haa550f, 24'h123456, 24'h000081);
    vt[8]  = mk(64'h47_00_00_00_00_00_00_00, 1, 0, 0, 0, 8'h00, 24'haa550f, 24'h123456, 24'h000081);
    vt[9]  = mk(64'h47_30_00_00_00_00_00_00, 2, 0, 1, 0, 8'h30, 24'haa550f, 24'h123456, 24'h000081);
    vt[10] = mk(64'h47_31_04_6c_0a_0b_0c_00, 7, 1, 1, 1, 8'h31, 24'h0a0b0c, 24'h123456, 24'h000081);
    vt[11] = mk(64'h47_32_04_64_ff_ee_dd_00, 7, 0, 1, 1, 8'h32, 24'h0a0b0c, 24'hffeedd, 24'h000081);
    vt[12] = mk(64'h47_33_04_6c_11_22_33_44, 8, 1, 1, 0, 8'h33, 24'h0a0b0c, 24'hffeedd, 24'h000081);

    reset               = 1'b0;
    in_frame_valid      = 1'b0;
    in_frame_data       = 8'h00;
    in_frame_data_valid = 1'b0;
    ack_ready           = 1'b0;
    #23;
    check_regs("reset", 24'h0, 24'h0, 24'h0);
    chk("reset.ack_valid", 32'(ack_valid), 32'd0);
    chk("reset.ack_ok", 32'(ack_ok), 32'd0);
    chk("reset.ack_id", 32'(ack_event_id), 32'd0);
    chk("reset.ready", 32'(in_frame_ready), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 13; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_frame(tag, vt[v].bytes, vt[v].n, vt[v].simul, vt[v].exp_ack, vt[v].exp_ok,
                vt[v].exp_id);
      check_regs(tag, vt[v].exp_lvl, vt[v].exp_dir, vt[v].exp_ien);
    end

    // Second frame offered while the first ack is held for 10 cycles.
    for (int i = 0; i < 7; i++) begin
      logic [55:0] fa;
      fa = 56'h47_40_04_6c_01_02_03;
      in_frame_valid = 1'b1; in_frame_data = fa[55-8*i -: 8]; in_frame_data_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_frame_valid = 1'b0; in_frame_data_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold.ack_a", 32'(ack_valid), 32'd1);
    chk("hold.id_a", 32'(ack_event_id), 32'h40);
    in_frame_valid = 1'b1; in_frame_data = 8'h47; in_frame_data_valid = 1'b1;
    busy = 0; lost_valid = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (in_frame_ready) busy++;
      if (!ack_valid) lost_valid++;
    end
    chk("hold.ready_low_cycles", 32'(busy), 32'd0);
    chk("hold.ack_stays", 32'(lost_valid), 32'd0);
    check_regs("hold.a", 24'h010203, 24'hffeedd, 24'h000081);
    ack_ready = 1'b1;
    @(posedge clk); #1;
    ack_ready = 1'b0;
    chk("hold.ready_back", 32'(in_frame_ready), 32'd1);
    @(posedge clk); #1;
    run_frame("hold.b", 64'h41_04_64_0a_0b_0c_00_00, 6, 0, 1, 1, 8'h41);
    check_regs("hold.b", 24'h010203, 24'h0a0b0c, 24'h000081);

    // Reset pulse in the middle of the data bytes.
    for (int i = 0; i < 5; i++) begin
      logic [39:0] fr;
      fr = 40'h47_50_04_6c_11;
      in_frame_valid = 1'b1; in_frame_data = fr[39-8*i -: 8]; in_frame_data_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_frame_data_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_regs("rst_mid", 24'h0, 24'h0, 24'h0);
    chk("rst_mid.ack_valid", 32'(ack_valid), 32'd0);
    chk("rst_mid.ack_id", 32'(ack_event_id), 32'd0);
    chk("rst_mid.ready", 32'(in_frame_ready), 32'd1);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    run_frame("rst_tail", 64'h22_33_00_00_00_00_00_00, 2, 0, 0, 0, 8'h00);
    check_regs("rst_tail", 24'h0, 24'h0, 24'h0);
    run_frame("rst_next", 64'h47_51_04_69_00_00_07_00, 7, 0, 1, 1, 8'h51);
    check_regs("rst_next", 24'h0, 24'h0, 24'h000007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
